outport_vc_grant_responder: RTL and testbench

- Output-port-side responder for input-VC route requests.
- Each input port presents:
  - a per-outport request bit (its out_vec bit for this outport);
  - the requesting input VC id (invc_req);
  - a mask of acceptable output VCs (out_allow_vcs).
- One instance per output port. Each grant round it round-robin arbitrates among requesting inports, allocates the lowest free allowed output VC, and returns a one-cycle ok bit to the winner. The winning inport then clears that outport from its residual request vector.
- Tracks output-VC occupancy until a tail release frees the VC.

---
 rtl/outport_vc_grant_responder_if.sv | 32 +++
 rtl/outport_vc_grant_responder.sv | 163 ++++++++++++++++
 tb/tb_outport_vc_grant_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/outport_vc_grant_responder_if.sv
// Request/grant/release bundle between the input ports and one output-port
// VC grant responder. The requester side drives the requests and releases.
// The responder side drives the grant pulse and the VC occupancy.
interface outport_vc_grant_responder_if #(
  parameter int unsigned no_inport                   = 6,
  parameter int unsigned no_vc                       = 13,
  parameter int unsigned floorplusone_log2_no_vc     = 4,
  parameter int unsigned floorplusone_log2_no_inport = 3
);
  logic                                            en;
  logic [no_inport-1:0]                            req_vec;
  logic [no_inport*floorplusone_log2_no_vc-1:0]    req_invc;
  logic [no_inport*no_vc-1:0]                      req_allow_vcs;
  logic                                            release_valid;
  logic [floorplusone_log2_no_vc-1:0]              release_vc;
  logic [no_inport-1:0]                            ok_vec;
  logic                                            grant_valid;
  logic [floorplusone_log2_no_inport-1:0]          grant_inport;
  logic [floorplusone_log2_no_vc-1:0]              grant_invc;
  logic [floorplusone_log2_no_vc-1:0]              grant_outvc;
  logic [no_vc-1:0]                                vc_busy;

  modport master (
    output en, req_vec, req_invc, req_allow_vcs, release_valid, release_vc,
    input  ok_vec, grant_valid, grant_inport, grant_invc, grant_outvc, vc_busy
  );

  modport slave (
    input  en, req_vec, req_invc, req_allow_vcs, release_valid, release_vc,
    output ok_vec, grant_valid, grant_inport, grant_invc, grant_outvc, vc_busy
  );
endinterface

// File: rtl/outport_vc_grant_responder.sv
// Output-port VC grant responder.
// The block round-robins among the eligible input ports. It allocates the
// lowest free allowed output VC to the winner. It returns a one-cycle ok pulse,
// then waits one dead cycle so the requester's residual vector can settle.
// The block tracks which output VCs are busy until a tail release frees them.
module outport_vc_grant_responder #(
  parameter int unsigned no_inport                   = 6,
  parameter int unsigned no_vc                       = 13,
  parameter int unsigned floorplusone_log2_no_vc     = 4,
  parameter int unsigned floorplusone_log2_no_inport = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  outport_vc_grant_responder_if.slave    bus
);

  localparam int unsigned VW = floorplusone_log2_no_vc;
  localparam int unsigned IW = floorplusone_log2_no_inport;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [no_inport-1:0] ok_q;
  logic                 grant_valid_q;
  logic [IW-1:0]        grant_inport_q;
  logic [VW-1:0]        grant_invc_q;
  logic [VW-1:0]        grant_outvc_q;
  logic [no_vc-1:0]     vc_busy_q;

  logic [VW-1:0]        invc  [no_inport];
  logic [no_vc-1:0]     avail [no_inport];
  logic [no_inport-1:0] eligible;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [no_inport-1:0] win_onehot;
  logic [VW-1:0]        win_invc;
  logic [no_vc-1:0]     win_avail;

  logic [VW-1:0]        win_outvc;
  logic [no_vc-1:0]     win_vc_onehot;
  logic                 take_grant;
  logic [no_vc-1:0]     alloc_mask;
  logic [no_vc-1:0]     rel_mask;
  logic [IW-1:0]        rr_next;

  // Slice the per-inport fields and decide which inports may be granted
  always_comb begin
    for (int unsigned i = 0; i < no_inport; i++) begin
      invc[i]     = bus.req_invc[i*VW +: VW];
      avail[i]    = bus.req_allow_vcs[i*no_vc +: no_vc] & ~vc_busy_q;
      eligible[i] = bus.req_vec[i] && (invc[i] != '0) && (avail[i] != '0);
    end
  end

  // Round-robin search: the first eligible inport at or after rr_ptr, with wrap
  always_comb begin
    int unsigned cand;
    cand       = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_invc   = '0;
    win_avail  = '0;
    for (int unsigned off = 0; off < no_inport; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= no_inport) cand = cand - no_inport;
      if (!win_found && eligible[cand[IW-1:0]]) begin
        win_found             = 1'b1;
        win_idx               = cand[IW-1:0];
        win_onehot[cand[IW-1:0]] = 1'b1;
        win_invc              = invc[cand[IW-1:0]];
        win_avail             = avail[cand[IW-1:0]];
      end
    end
  end

  // Pick the lowest free allowed output VC for the winner (ids start at 1)
  always_comb begin
    win_outvc     = '0;
    win_vc_onehot = '0;
    for (int unsigned k = 0; k < no_vc; k++) begin
      if (win_avail[k] && (win_outvc == '0)) begin
        win_outvc        = VW'(k + 1);
        win_vc_onehot[k] = 1'b1;
      end
    end
  end

  // Decode the grant, the release and the pointer advance.
  // Out-of-range release ids match no bit, so they are ignored here.
  always_comb begin
    take_grant = (state == IDLE) && bus.en && win_found;
    alloc_mask = take_grant ? win_vc_onehot : '0;
    rel_mask   = '0;
    for (int unsigned k = 0; k < no_vc; k++) begin
      if (bus.release_valid && (bus.release_vc == VW'(k + 1))) rel_mask[k] = 1'b1;
    end
    rr_next = (win_idx == IW'(no_inport - 1)) ? '0 : win_idx + 1'b1;
  end

  // Grant FSM with registered outputs and VC occupancy tracking.
  // Allocation uses the busy vector from before the release, so a VC freed in
  // this cycle can only be granted on the next IDLE evaluation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      ok_q           <= '0;
      grant_valid_q  <= 1'b0;
      grant_inport_q <= '0;
      grant_invc_q   <= '0;
      grant_outvc_q  <= '0;
      vc_busy_q      <= '0;
    end else begin
      vc_busy_q <= (vc_busy_q & ~rel_mask) | alloc_mask;
      case (state)
        IDLE: begin
          if (take_grant) begin
            ok_q           <= win_onehot;
            grant_valid_q  <= 1'b1;
            grant_inport_q <= win_idx;
            grant_invc_q   <= win_invc;
            grant_outvc_q  <= win_outvc;
            rr_ptr         <= rr_next;
            state          <= GRANT;
          end
        end
        GRANT: begin
          ok_q           <= '0;
          grant_valid_q  <= 1'b0;
          grant_inport_q <= '0;
          grant_invc_q   <= '0;
          grant_outvc_q  <= '0;
          state          <= HOLD;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ok_vec       = ok_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_inport = grant_inport_q;
  assign bus.grant_invc   = grant_invc_q;
  assign bus.grant_outvc  = grant_outvc_q;
  assign bus.vc_busy      = vc_busy_q;

  // Grant pulses are one-hot, last exactly one cycle, and never name VC 0
  a_ok_onehot: assert property (@(posedge clk) disable iff (reset)
    grant_valid_q |-> $onehot(ok_q));
  a_one_cycle: assert property (@(posedge clk) disable iff (reset)
    grant_valid_q |=> !grant_valid_q);
  a_outvc_nonzero: assert property (@(posedge clk) disable iff (reset)
    grant_valid_q |-> (grant_outvc_q != '0));

endmodule

// File: tb/tb_outport_vc_grant_responder.sv
// Bench for the output-port VC grant responder.
// A table of per-cycle vectors gives the expected grant and occupancy after
// each clock edge. Expected grant details go into a scoreboard, and they are
// compared when the DUT raises grant_valid.
module tb_outport_vc_grant_responder;

  logic clk;
  logic reset;

  outport_vc_grant_responder_if #(
    .no_inport(6), .no_vc(13), .floorplusone_log2_no_vc(4), .floorplusone_log2_no_inport(3)
  ) bus ();

  outport_vc_grant_responder #(
    .no_inport(6), .no_vc(13), .floorplusone_log2_no_vc(4), .floorplusone_log2_no_inport(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [5:0]  req;
    logic [23:0] invc;
    logic [77:0] allow;
    logic        rv;
    logic [3:0]  rvc;
    logic        eg;
    logic [2:0]  ei;
    logic [3:0]  einvc;
    logic [3:0]  eo;
    logic [12:0] ebusy;
  } vec_t;

  typedef struct {
    logic [2:0] ip;
    logic [3:0] iv;
    logic [3:0] ov;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   vi = 0;

  localparam logic [77:0] ALL = '1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, vi, got, exp);
    end
  endtask

  function automatic logic [77:0] mk_allow(input int i, input logic [12:0] m);
    return 78'(m) << (i * 13);
  endfunction

  function automatic logic [23:0] mk_invc(input int i, input logic [3:0] v);
    return 24'(v) << (i * 4);
  endfunction

  task automatic add(input logic rst, input logic en, input logic [5:0] req,
                     input logic [23:0] invc, input logic [77:0] allow,
                     input logic rv, input logic [3:0] rvc,
                     input logic eg, input logic [2:0] ei, input logic [3:0] einvc,
                     input logic [3:0] eo, input logic [12:0] ebusy);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.invc = invc; v.allow = allow;
    v.rv = rv; v.rvc = rvc; v.eg = eg; v.ei = ei; v.einvc = einvc; v.eo = eo;
    v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [12:0] b);
    add(1'b0, 1'b1, 6'b0, 24'b0, 78'b0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, b);
  endtask

  task automatic rst_vec();
    add(1'b1, 1'b1, 6'b0, 24'b0, 78'b0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 13'h0);
  endtask

  // Scoreboard side: every grant pulse must match the oldest expected grant
  always @(negedge clk) begin
    if (bus.grant_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_grant got inport=%0d outvc=%0d exp none",
                 bus.grant_inport, bus.grant_outvc);
      end else begin
        e = sb.pop_front();
        chk("sb_inport", 32'(bus.grant_inport), 32'(e.ip));
        chk("sb_invc",   32'(bus.grant_invc),   32'(e.iv));
        chk("sb_outvc",  32'(bus.grant_outvc),  32'(e.ov));
      end
    end
  end

  initial begin
    int gp[4];
    logic [23:0] inv3;
    logic [12:0] b;
    vec_t v;
    gp = '{0, 3, 5, 0};

    // Single request from inport 2, allow VC2/VC3 -> VC2, then two quiet cycles
    rst_vec();
    add(1'b0, 1'b1, 6'b000100, mk_invc(2, 4'd3), mk_allow(2, 13'h0006), 1'b0, 4'd0,
        1'b1, 3'd2, 4'd3, 4'd2, 13'h0002);
    idle(13'h0002);
    idle(13'h0002);

    // Inports 0, 3, 5 held -> order 0, 3, 5, 0 every third cycle
    rst_vec();
    inv3 = mk_invc(0, 4'd1) | mk_invc(3, 4'd4) | mk_invc(5, 4'd6);
    for (int g = 0; g < 4; g++) begin
      b = 13'((1 << (g + 1)) - 1);
      add(1'b0, 1'b1, 6'b101001, inv3, ALL, 1'b0, 4'd0,
          1'b1, 3'(gp[g]), 4'(gp[g] + 1), 4'(g + 1), b);
      add(1'b0, 1'b1, 6'b101001, inv3, ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, b);
      add(1'b0, 1'b1, 6'b101001, inv3, ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, b);
    end

    // Fill every VC from inport 0
    rst_vec();
    for (int k = 0; k < 13; k++) begin
      b = 13'((1 << (k + 1)) - 1);
      add(1'b0, 1'b1, 6'b000001, mk_invc(0, 4'd1), ALL, 1'b0, 4'd0,
          1'b1, 3'd0, 4'd1, 4'(k + 1), b);
      idle(b);
      idle(b);
    end
    // All busy: inport 1 waits, release VC7 (unseen this cycle), then VC7 granted
    add(1'b0, 1'b1, 6'b000010, mk_invc(1, 4'd2), ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFF);
    add(1'b0, 1'b1, 6'b000010, mk_invc(1, 4'd2), ALL, 1'b1, 4'd7, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FBF);
    add(1'b0, 1'b1, 6'b000010, mk_invc(1, 4'd2), ALL, 1'b0, 4'd0, 1'b1, 3'd1, 4'd2, 4'd7, 13'h1FFF);
    idle(13'h1FFF);
    idle(13'h1FFF);

    // Same-VC release and request in one cycle: no grant, then VC5 granted
    add(1'b0, 1'b1, 6'b000100, mk_invc(2, 4'd5), mk_allow(2, 13'h0010), 1'b1, 4'd5,
        1'b0, 3'd0, 4'd0, 4'd0, 13'h1FEF);
    add(1'b0, 1'b1, 6'b000100, mk_invc(2, 4'd5), mk_allow(2, 13'h0010), 1'b0, 4'd0,
        1'b1, 3'd2, 4'd5, 4'd5, 13'h1FFF);
    idle(13'h1FFF);
    idle(13'h1FFF);

    // Out-of-range releases are ignored, VC3 release works
    add(1'b0, 1'b1, 6'b0, 24'b0, 78'b0, 1'b1, 4'd0,  1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFF);
    add(1'b0, 1'b1, 6'b0, 24'b0, 78'b0, 1'b1, 4'd14, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFF);
    add(1'b0, 1'b1, 6'b0, 24'b0, 78'b0, 1'b1, 4'd15, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFF);
    add(1'b0, 1'b1, 6'b0, 24'b0, 78'b0, 1'b1, 4'd3,  1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFB);
    // invc 0 never granted
    add(1'b0, 1'b1, 6'b010000, mk_invc(4, 4'd0), ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFB);
    add(1'b0, 1'b1, 6'b010000, mk_invc(4, 4'd0), ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFB);
    // en=0 holds off grants until en returns
    add(1'b0, 1'b0, 6'b000010, mk_invc(1, 4'd2), ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFB);
    add(1'b0, 1'b0, 6'b000010, mk_invc(1, 4'd2), ALL, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, 13'h1FFB);
    add(1'b0, 1'b1, 6'b000010, mk_invc(1, 4'd2), ALL, 1'b0, 4'd0, 1'b1, 3'd1, 4'd2, 4'd3, 13'h1FFF);
    idle(13'h1FFF);
    idle(13'h1FFF);

    // Reset during GRANT clears everything. The pointer restarts at inport 0.
    rst_vec();
    add(1'b0, 1'b1, 6'b001000, mk_invc(3, 4'd4), ALL, 1'b0, 4'd0, 1'b1, 3'd3, 4'd4, 4'd1, 13'h0001);
    add(1'b1, 1'b1, 6'b001010, mk_invc(1, 4'd2) | mk_invc(3, 4'd4), ALL, 1'b0, 4'd0,
        1'b0, 3'd0, 4'd0, 4'd0, 13'h0000);
    add(1'b0, 1'b1, 6'b001010, mk_invc(1, 4'd2) | mk_invc(3, 4'd4), ALL, 1'b0, 4'd0,
        1'b1, 3'd1, 4'd2, 4'd1, 13'h0001);
    idle(13'h0001);
    idle(13'h0001);

    reset = 1'b1;
    bus.en = 1'b0; bus.req_vec = '0; bus.req_invc = '0; bus.req_allow_vcs = '0;
    bus.release_valid = 1'b0; bus.release_vc = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      vi = i;
      v = vecs[i];
      reset             = v.rst;
      bus.en            = v.en;
      bus.req_vec       = v.req;
      bus.req_invc      = v.invc;
      bus.req_allow_vcs = v.allow;
      bus.release_valid = v.rv;
      bus.release_vc    = v.rvc;
      if (v.eg) sb.push_back('{v.ei, v.einvc, v.eo});
      @(posedge clk);
      #1;
      chk("grant_valid", 32'(bus.grant_valid), 32'(v.eg));
      chk("ok_vec", 32'(bus.ok_vec), v.eg ? (32'd1 << v.ei) : 32'd0);
      chk("vc_busy", 32'(bus.vc_busy), 32'(v.ebusy));
      if (!v.eg) begin
        chk("idle_inport", 32'(bus.grant_inport), 32'd0);
        chk("idle_invc",   32'(bus.grant_invc),   32'd0);
        chk("idle_outvc",  32'(bus.grant_outvc),  32'd0);
      end
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
